// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: NOP encoding,
// controller state encoding and register index type.
package pipe_hazard_ctrl_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int unsigned REG_W     = 3;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_t;

    // True when an operand is actually read and names the given destination.
    function automatic logic src_hit(input logic uses, input reg_idx_t src, input reg_idx_t dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the
// datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    logic     id_uses_rs;
    logic     id_uses_rt;
    logic     id_halt;
    logic     idex_mem_read;
    reg_idx_t idex_rd;
    logic     ex_branch_taken;
    logic     imem_stall;
    logic     dmem_stall;

    logic     pc_we;
    logic     ifid_we;
    logic     ifid_flush;
    logic     idex_bubble;
    logic     idex_we;
    logic     exmem_we;
    logic     memwb_bubble;
    logic     halted;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
               idex_mem_read, idex_rd, ex_branch_taken, imem_stall, dmem_stall,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, idex_we,
               exmem_we, memwb_bubble, halted
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
               idex_mem_read, idex_rd, ex_branch_taken, imem_stall, dmem_stall,
        output pc_we, ifid_we, ifid_flush, idex_bubble, idex_we,
               exmem_we, memwb_bubble, halted
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register
// that the load currently in EX has not yet produced.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rs,
    input  logic     id_uses_rt,
    input  logic     idex_mem_read,
    input  reg_idx_t idex_rd,
    output logic     load_use
);

    assign load_use = idex_mem_read &&
                      (src_hit(id_uses_rs, id_rs, idex_rd) ||
                       src_hit(id_uses_rt, id_rt, idex_rd));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls, flushes and bubbles from
// hazards and memory waits, plus HALT drain into a sticky halted state.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] drain_cnt;
    logic             load_use;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .id_uses_rs    (bus.id_uses_rs),
        .id_uses_rt    (bus.id_uses_rt),
        .idex_mem_read (bus.idex_mem_read),
        .idex_rd       (bus.idex_rd),
        .load_use      (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // HALT only leaves ID when nothing of higher priority holds or squashes it.
                    if (!bus.dmem_stall && !bus.ex_branch_taken && !load_use && bus.id_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.dmem_stall) begin
                        if (drain_cnt == '0) begin
                            state <= ST_HALTED;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: ;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        bus.pc_we        = 1'b0;
        bus.ifid_we      = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.idex_bubble  = 1'b0;
        bus.idex_we      = 1'b0;
        bus.exmem_we     = 1'b0;
        bus.memwb_bubble = 1'b1;
        bus.halted       = 1'b0;

        if (rst) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.idex_we     = 1'b1;
            bus.exmem_we    = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!bus.dmem_stall) begin
                        bus.idex_we      = 1'b1;
                        bus.exmem_we     = 1'b1;
                        bus.memwb_bubble = 1'b0;
                        if (bus.ex_branch_taken) begin
                            bus.pc_we       = 1'b1;
                            bus.ifid_we     = 1'b1;
                            bus.ifid_flush  = 1'b1;
                            bus.idex_bubble = 1'b1;
                        end else if (load_use) begin
                            bus.idex_bubble = 1'b1;
                        end else if (bus.id_halt) begin
                            bus.idex_bubble = 1'b0;
                        end else if (bus.imem_stall) begin
                            bus.ifid_we    = 1'b1;
                            bus.ifid_flush = 1'b1;
                        end else begin
                            bus.pc_we   = 1'b1;
                            bus.ifid_we = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!bus.dmem_stall) begin
                        bus.idex_bubble  = 1'b1;
                        bus.idex_we      = 1'b1;
                        bus.exmem_we     = 1'b1;
                        bus.memwb_bubble = 1'b0;
                    end
                end
                ST_HALTED: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
